// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with write-through bypass and RAW issue scoreboard
module regfile_scoreboard #(
    parameter int INWIDTH = 5,
    parameter int DWIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    input  logic [2**INWIDTH-1:0]   wr_onehot,
    input  logic [DWIDTH-1:0]       wr_data,
    input  logic [INWIDTH-1:0]      rs1_addr,
    input  logic [INWIDTH-1:0]      rs2_addr,
    output logic [DWIDTH-1:0]       rs1_data,
    output logic [DWIDTH-1:0]       rs2_data,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    input  logic                    iss_valid,
    input  logic [INWIDTH-1:0]      iss_rd,
    output logic                    wr_err
);
    localparam int NREG = 2 ** INWIDTH;
    localparam logic [NREG-1:0] ONE = NREG'(1);

    logic [DWIDTH-1:0] regs [NREG];
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic [NREG-1:0]   wr_hit;
    logic [NREG-1:0]   iss_set;
    logic              onehot_ok;
    logic              wr_legal;

    // wr_hit is the effective write-enable vector: zero unless the write is legal, never bit 0
    always_comb begin
        onehot_ok = (wr_onehot != '0) && ((wr_onehot & (wr_onehot - ONE)) == '0);
        wr_legal  = wr_valid && onehot_ok;
        wr_hit    = wr_legal ? wr_onehot : '0;
        wr_hit[0] = 1'b0;
        iss_set   = '0;
        if (iss_valid && (iss_rd != '0)) begin
            iss_set[iss_rd] = 1'b1;
        end
        // a same-cycle issue re-marks the register because it is the newer producer
        pending_nxt = (pending & ~wr_hit) | iss_set;
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        if (wr_hit[rs1_addr]) begin
            rs1_data = wr_data;
        end
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end
        rs2_data = regs[rs2_addr];
        if (wr_hit[rs2_addr]) begin
            rs2_data = wr_data;
        end
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end
        rs1_busy = pending[rs1_addr] & ~wr_hit[rs1_addr];
        rs2_busy = pending[rs2_addr] & ~wr_hit[rs2_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
            wr_err  <= 1'b0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_hit[i]) begin
                    regs[i] <= wr_data;
                end
            end
            pending <= pending_nxt;
            if (wr_valid && !onehot_ok) begin
                wr_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed and randomized checks of regfile_scoreboard against a reference model
module tb_regfile_scoreboard;
    localparam int INW  = 5;
    localparam int NREG = 32;
    localparam int DW   = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_valid;
    logic [NREG-1:0] wr_onehot;
    logic [DW-1:0]   wr_data;
    logic [INW-1:0]  rs1_addr;
    logic [INW-1:0]  rs2_addr;
    logic [DW-1:0]   rs1_data;
    logic [DW-1:0]   rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            iss_valid;
    logic [INW-1:0]  iss_rd;
    logic            wr_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] m_regs [NREG];
    bit            m_pend [NREG];
    bit            m_err;

    regfile_scoreboard #(.INWIDTH(INW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_onehot(wr_onehot), .wr_data(wr_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    function automatic int tgt_of(input logic [NREG-1:0] oh);
        if ($countones(oh) != 1) return -1;
        for (int i = 0; i < NREG; i++) if (oh[i]) return i;
        return -1;
    endfunction

    function automatic logic [DW-1:0] exp_read(input int a);
        int t = tgt_of(wr_onehot);
        if (a == 0) return '0;
        if (wr_valid && t == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
        int t = tgt_of(wr_onehot);
        if (a == 0) return 1'b0;
        return m_pend[a] && !(wr_valid && t == a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        int t = tgt_of(wr_onehot);
        if (wr_valid && t < 0) m_err = 1'b1;
        if (wr_valid && t > 0) begin
            m_regs[t] = wr_data;
            m_pend[t] = 1'b0;
        end
        if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rs1_data"}, rs1_data, exp_read(int'(rs1_addr)));
        chk({tag, ".rs2_data"}, rs2_data, exp_read(int'(rs2_addr)));
        chk({tag, ".rs1_busy"}, DW'(rs1_busy), DW'(exp_busy(int'(rs1_addr))));
        chk({tag, ".rs2_busy"}, DW'(rs2_busy), DW'(exp_busy(int'(rs2_addr))));
        chk({tag, ".wr_err"}, DW'(wr_err), DW'(m_err));
    endtask

    task automatic set_in(input logic wv, input logic [NREG-1:0] oh, input logic [DW-1:0] wd,
                          input logic [INW-1:0] a1, input logic [INW-1:0] a2,
                          input logic iv, input logic [INW-1:0] rd);
        wr_valid  = wv;
        wr_onehot = oh;
        wr_data   = wd;
        rs1_addr  = a1;
        rs2_addr  = a2;
        iss_valid = iv;
        iss_rd    = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    initial begin
        logic [NREG-1:0] oh;
        int tgt;
        rst_n = 1'b0;
        set_in(0, '0, '0, '0, '0, 0, '0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NREG; i++) begin
            set_in(0, '0, '0, INW'(i), INW'(NREG - 1 - i), 0, '0);
            #1 check_all("reset");
            tick();
        end

        // bypass then stored value
        set_in(1, NREG'(1) << 5, 32'hDEADBEEF, 5, 0, 0, 0);
        #1 check_all("wr5_bypass");
        chk("wr5_bypass_const", rs1_data, 32'hDEADBEEF);
        tick();
        set_in(0, '0, '0, 5, 5, 0, 0);
        #1 check_all("wr5_stored");
        chk("wr5_stored_const", rs2_data, 32'hDEADBEEF);
        tick();

        // register 0 ignores writes and issues
        set_in(1, NREG'(1), 32'h1234, 0, 0, 1, 0);
        #1 check_all("r0_wr");
        tick();
        set_in(0, '0, '0, 0, 0, 0, 0);
        #1 check_all("r0_after");
        chk("r0_busy_const", DW'(rs1_busy), 0);
        tick();

        // RAW stall on 7, released by writeback
        set_in(0, '0, '0, 0, 7, 1, 7);
        #1 check_all("iss7");
        chk("iss7_busy_same_cycle", DW'(rs2_busy), 0);
        tick();
        set_in(0, '0, '0, 0, 7, 0, 0);
        #1 check_all("iss7_pending");
        chk("iss7_busy_const", DW'(rs2_busy), 1);
        tick();
        set_in(1, NREG'(1) << 7, 32'h55, 0, 7, 0, 0);
        #1 check_all("wb7");
        chk("wb7_busy_const", DW'(rs2_busy), 0);
        chk("wb7_data_const", rs2_data, 32'h55);
        tick();
        set_in(0, '0, '0, 7, 7, 0, 0);
        #1 check_all("wb7_after");
        chk("wb7_after_busy_const", DW'(rs1_busy), 0);
        tick();

        // same-cycle issue and write: newer producer keeps pending
        set_in(1, NREG'(1) << 9, 32'hA, 9, 0, 1, 9);
        #1 check_all("iss_wr9");
        tick();
        set_in(0, '0, '0, 9, 9, 0, 0);
        #1 check_all("iss_wr9_after");
        chk("iss_wr9_busy_const", DW'(rs1_busy), 1);
        chk("iss_wr9_data_const", rs1_data, 32'hA);
        tick();

        // randomized legal traffic; garbage wr_onehot only while wr_valid=0
        for (int n = 0; n < 400; n++) begin
            tgt = int'($urandom_range(0, NREG - 1));
            wr_valid  = ($urandom_range(0, 3) != 0);
            wr_onehot = wr_valid ? (NREG'(1) << tgt) : NREG'($urandom);
            wr_data   = $urandom;
            rs1_addr  = ($urandom_range(0, 3) == 0) ? INW'(tgt) : INW'($urandom_range(0, NREG - 1));
            rs2_addr  = INW'($urandom_range(0, NREG - 1));
            iss_valid = $urandom_range(0, 1) != 0;
            iss_rd    = ($urandom_range(0, 3) == 0) ? INW'(tgt) : INW'($urandom_range(0, NREG - 1));
            #1 check_all("rand");
            tick();
        end

        set_in(1, NREG'(1) << 1, 32'h77, 0, 0, 0, 0);
        #1 check_all("wr1");
        tick();

        // multi-hot write is rejected and flagged
        oh = NREG'(3);
        set_in(1, oh, 32'hFF, 0, 1, 0, 0);
        #1 check_all("multihot");
        tick();
        set_in(0, '0, '0, 0, 1, 0, 0);
        #1 check_all("multihot_after");
        chk("multihot_err_const", DW'(wr_err), 1);
        chk("multihot_r1_const", rs2_data, 32'h77);
        tick();
        set_in(0, '0, '0, 1, 5, 0, 0);
        #1 check_all("err_sticky");
        tick();

        // asynchronous reset between edges, with a write and issue in flight
        set_in(1, NREG'(1) << 3, 32'hCAFE, 3, 1, 1, 3);
        #1 check_all("pre_rst");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_err", DW'(wr_err), 0);
        chk("async_rst_r1", rs2_data, 32'h0);
        chk("async_rst_busy", DW'(rs2_busy), 0);
        tick();
        set_in(0, '0, '0, 3, 3, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            set_in(0, '0, '0, INW'(i), INW'((i + 3) % NREG), 0, '0);
            #1 check_all("post_rst");
            tick();
        end

        // wr_valid=0 hides an all-zero enable; wr_valid=1 flags it
        set_in(0, '0, 32'h1, 0, 0, 0, 0);
        #1 check_all("zero_oh_idle");
        tick();
        set_in(0, '0, '0, 0, 0, 0, 0);
        #1 check_all("zero_oh_idle_after");
        set_in(1, '0, 32'h1, 0, 0, 0, 0);
        #1 check_all("zero_oh");
        tick();
        set_in(0, '0, '0, 0, 0, 0, 0);
        #1 check_all("zero_oh_after");
        chk("zero_oh_err_const", DW'(wr_err), 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
